// File: rtl/apb_cmd_master.sv
// APB command master: converts a valid/ready command stream into single
// APB SETUP/ACCESS transfers and returns one response per command.
// One transfer is in flight at a time; an optional access-phase timeout
// aborts a transfer whose slave never raises PREADY.
module apb_cmd_master #(
    parameter int unsigned PADDR_SIZE = 12,
    parameter int unsigned PDATA_SIZE = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    // command stream
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PADDR_SIZE-1:0] req_addr,
    input  logic                  req_write,
    input  logic [PDATA_SIZE-1:0] req_wdata,

    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    // APB initiator side
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [PDATA_SIZE-1:0] PWDATA,
    input  logic [PDATA_SIZE-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // The wait counter is 16 bits (TIMEOUT tops out at 65535); the limit
    // is held one bit wider so the incremented count compares without wrap.
    localparam int unsigned CNT_W       = 16;
    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT);
    localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_cnt_next;
    logic [CNT_W:0]        wait_cnt_inc;

    logic                  psel_next;
    logic                  penable_next;
    logic [PADDR_SIZE-1:0] paddr_next;
    logic                  pwrite_next;
    logic [PDATA_SIZE-1:0] pwdata_next;
    logic                  rsp_valid_next;
    logic [PDATA_SIZE-1:0] rsp_rdata_next;
    logic                  rsp_err_next;
    logic                  rsp_timeout_next;

    // Only the command handshake is combinational; everything else is a flop.
    assign req_ready    = (state == IDLE);

    // Count of ACCESS cycles seen with PREADY low, including the current one.
    assign wait_cnt_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // State, wait counter and every registered output; all cleared by reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            PSEL        <= psel_next;
            PENABLE     <= penable_next;
            PADDR       <= paddr_next;
            PWRITE      <= pwrite_next;
            PWDATA      <= pwdata_next;
            rsp_valid   <= rsp_valid_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_err     <= rsp_err_next;
            rsp_timeout <= rsp_timeout_next;
        end
    end

    // Next state and next values of the registered outputs (hold by default).
    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        psel_next        = PSEL;
        penable_next     = PENABLE;
        paddr_next       = PADDR;
        pwrite_next      = PWRITE;
        pwdata_next      = PWDATA;
        rsp_valid_next   = rsp_valid;
        rsp_rdata_next   = rsp_rdata;
        rsp_err_next     = rsp_err;
        rsp_timeout_next = rsp_timeout;

        unique case (state)
            IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (req_valid) begin
                    // Address/direction/data are captured here and then
                    // stay untouched until the next accepted command.
                    paddr_next    = req_addr;
                    pwrite_next   = req_write;
                    pwdata_next   = req_wdata;
                    psel_next     = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = SETUP;
                end
            end

            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    // A ready slave always wins, even on the cycle the
                    // timeout would otherwise have fired.
                    rsp_rdata_next   = PWRITE ? '0 : PRDATA;
                    rsp_err_next     = PSLVERR;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    state_next       = RESP;
                end else begin
                    // Saturate so a disabled timeout never wraps the count.
                    if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt_next = wait_cnt_inc[CNT_W-1:0];
                    end
                    if (TIMEOUT_EN && (wait_cnt_inc >= TIMEOUT_LIM)) begin
                        rsp_rdata_next   = '0;
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        rsp_valid_next   = 1'b1;
                        psel_next        = 1'b0;
                        penable_next     = 1'b0;
                        state_next       = RESP;
                    end
                end
            end

            RESP: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: a table of directed transfers,
// a reset-during-ACCESS sequence, and randomized transfers checked against
// a transfer-level model of latency, bus activity and response contents.
module tb_apb_cmd_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model: PREADY rises after cur_wait low ACCESS cycles.
    int          cur_wait = 0;
    logic [DW-1:0] cur_rdata = '0;
    logic        cur_err = 1'b0;
    int          acc_cnt = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= cur_wait);
    assign PRDATA  = cur_rdata;
    assign PSLVERR = cur_err;

    apb_cmd_master #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            wt;
        logic [DW-1:0] rdata;
        logic          err;
        int            hold;
        int            exp_lat;
        logic          exp_err;
        logic          exp_to;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer-level reference: a transfer times out iff the slave would
    // keep PREADY low for TO or more ACCESS cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to    = (TO != 0) && (v.wt >= TO);
        r.exp_lat   = r.exp_to ? (2 + TO) : (3 + v.wt);
        r.exp_err   = r.exp_to ? 1'b1 : v.err;
        r.exp_rdata = (r.exp_to || v.wr) ? '0 : v.rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int k;
        int psel_n;
        int pen_n;
        int unstable;
        int hold_bad;
        int exp_acc;
        logic [DW-1:0] held_rdata;
        logic held_err;
        logic held_to;
        exp_acc = v.exp_to ? TO : v.wt + 1;
        @(negedge PCLK);
        cur_wait  = v.wt;
        cur_rdata = v.rdata;
        cur_err   = v.err;
        chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_write = v.wr;
        req_wdata = v.wdata;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
        k = 1; psel_n = 0; pen_n = 0; unstable = 0;
        while (!rsp_valid && k < 100) begin
            if (PSEL) begin
                psel_n++;
                if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata) unstable++;
            end
            if (PENABLE) pen_n++;
            if (req_ready) unstable++;
            @(negedge PCLK);
            k++;
        end
        chk({tag, " rsp_latency"}, 32'(k), 32'(v.exp_lat));
        chk({tag, " psel_cycles"}, 32'(psel_n), 32'(exp_acc + 1));
        chk({tag, " penable_cycles"}, 32'(pen_n), 32'(exp_acc));
        chk({tag, " addr_data_stable"}, 32'(unstable), 32'd0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        held_rdata = rsp_rdata; held_err = rsp_err; held_to = rsp_timeout;
        hold_bad = 0;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge PCLK);
            if (!rsp_valid || rsp_rdata !== held_rdata || rsp_err !== held_err ||
                rsp_timeout !== held_to || req_ready || PSEL || PENABLE) hold_bad++;
        end
        if (v.hold > 0) chk({tag, " rsp_hold_stable"}, 32'(hold_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid_cleared"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t rv;
        // addr, wr, wdata, wait, rdata, err, hold, exp_lat, exp_err, exp_to, exp_rdata
        vecs[0] = '{12'h010, 1'b1, 32'hDEADBEEF, 0,  32'h12345678, 1'b0, 0, 3, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{12'h104, 1'b0, 32'h00000000, 3,  32'h00000055, 1'b0, 0, 6, 1'b0, 1'b0, 32'h55};
        vecs[2] = '{12'h020, 1'b0, 32'h11111111, 0,  32'hA5A5A5A5, 1'b1, 0, 3, 1'b1, 1'b0, 32'hA5A5A5A5};
        vecs[3] = '{12'h024, 1'b1, 32'h0BADF00D, 0,  32'h22222222, 1'b0, 0, 3, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{12'h030, 1'b0, 32'h00000000, 10, 32'h00000077, 1'b1, 0, 6, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{12'h034, 1'b0, 32'h00000000, 3,  32'h00000099, 1'b0, 0, 6, 1'b0, 1'b0, 32'h99};
        vecs[6] = '{12'h040, 1'b0, 32'h33333333, 1,  32'hCAFEF00D, 1'b0, 5, 4, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[7] = '{12'hFFF, 1'b1, 32'hFFFFFFFF, 2,  32'h44444444, 1'b1, 1, 5, 1'b1, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(negedge PCLK);
        chk("rst psel", 32'(PSEL), 32'd0);
        chk("rst penable", 32'(PENABLE), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst paddr", 32'(PADDR), 32'd0);
        chk("rst pwdata", PWDATA, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err_to", 32'({rsp_err, rsp_timeout, PWRITE}), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst req_ready", 32'(req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset pulsed during ACCESS
        @(negedge PCLK);
        cur_wait = 10; cur_rdata = 32'h5A5A5A5A; cur_err = 1'b0;
        req_valid = 1'b1; req_addr = 12'h0AA; req_write = 1'b1; req_wdata = 32'h13572468;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        chk("midrst in_access", 32'({PSEL, PENABLE}), 32'd3);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst psel", 32'(PSEL), 32'd0);
        chk("midrst penable", 32'(PENABLE), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst paddr", 32'(PADDR), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst no_rsp", 32'(rsp_valid), 32'd0);
        rv = '{12'h0AB, 1'b0, 32'h0, 2, 32'h0000BEEF, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0};
        run_txn(model(rv), "postrst");

        // Randomized transfers against the transfer-level model
        for (int i = 0; i < 24; i++) begin
            rv.addr  = AW'($urandom);
            rv.wr    = 1'($urandom);
            rv.wdata = $urandom;
            rv.wt    = int'($urandom_range(0, 6));
            rv.rdata = $urandom;
            rv.err   = 1'($urandom);
            rv.hold  = int'($urandom_range(0, 3));
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
